// File: rtl/addatone_pkg.sv
// Shared types and helpers for the additive-synthesis control path:
// sequencer state type, width defaults and the 16-bit output saturator.
package addatone_pkg;

  localparam int DIVISOR_BITS_DEFAULT   = 7;
  localparam int SINE_ADDR_BITS_DEFAULT = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_PHASE,
    ST_SINE,
    ST_START,
    ST_ACK,
    ST_WAIT,
    ST_OUTPUT
  } seq_state_t;

  function automatic logic signed [15:0] sat16(input logic signed [31:0] i_value);
    if (i_value > 32'sd32767)
      return 16'h7FFF;
    else if (i_value < -32'sd32768)
      return 16'h8000;
    else
      return i_value[15:0];
  endfunction

endpackage

// File: rtl/harmonic_phase_ram.sv
// Per-harmonic 32-bit phase store: single port, synchronous read/write.
// After reset a sweep counter writes zero to every entry before o_Ready rises.
module harmonic_phase_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  input  logic [AW-1:0] i_Addr,
  input  logic          i_Wr_En,
  input  logic [31:0]   i_Wr_Data,
  output logic [31:0]   o_Rd_Data,
  output logic          o_Ready
);

  localparam logic [AW:0] SWEEP_END = (AW+1)'(DEPTH);

  logic [AW:0]   r_sweep;
  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_rd_data;
  logic          w_sweeping;
  logic [AW-1:0] w_addr;
  logic          w_we;
  logic [31:0]   w_wdata;

  assign w_sweeping = (r_sweep != SWEEP_END);
  assign w_addr     = w_sweeping ? r_sweep[AW-1:0] : i_Addr;
  assign w_we       = w_sweeping | i_Wr_En;
  assign w_wdata    = w_sweeping ? '0 : i_Wr_Data;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset)
      r_sweep <= '0;
    else if (w_sweeping)
      r_sweep <= r_sweep + 1'b1;
  end

  // No reset on the array or read register so the store maps onto block RAM.
  always_ff @(posedge i_Clock) begin
    if (w_we)
      r_mem[w_addr] <= w_wdata;
    r_rd_data <= r_mem[w_addr];
  end

  assign o_Rd_Data = r_rd_data;
  assign o_Ready   = ~w_sweeping;

endmodule

// File: rtl/harmonic_sequencer.sv
// Per-sample harmonic walker: advances each harmonic phase, fetches its sine
// value, hands {sample, multiple} to the adder and saturates the final total.
module harmonic_sequencer
  import addatone_pkg::*;
#(
  parameter int MAX_HARMONICS  = 64,
  parameter int DIVISOR_BITS   = DIVISOR_BITS_DEFAULT,
  parameter int SINE_ADDR_BITS = SINE_ADDR_BITS_DEFAULT,
  parameter int OUTPUT_SHIFT   = 6
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_Sample_Tick,
  input  logic [31:0]               i_Freq_Inc,
  input  logic [6:0]                i_Harmonic_Count,
  input  logic [DIVISOR_BITS-1:0]   i_Start_Level,
  input  logic [DIVISOR_BITS-1:0]   i_Level_Decay,
  output logic [SINE_ADDR_BITS-1:0] o_Sine_Addr,
  input  logic signed [15:0]        i_Sine_Data,
  output logic                      o_Clear_Accumulator,
  output logic                      o_Start,
  output logic [DIVISOR_BITS-1:0]   o_Multiple,
  output logic signed [15:0]        o_Sample,
  input  logic                      i_Adder_Done,
  input  logic signed [31:0]        i_Accumulator,
  output logic signed [15:0]        o_Output,
  output logic                      o_Output_Valid,
  output logic                      o_Overrun
);

  localparam int         HAW       = $clog2(MAX_HARMONICS);
  localparam logic [6:0] MAX_COUNT = 7'(MAX_HARMONICS);

  seq_state_t                r_state;
  logic [31:0]               r_freq;
  logic [32:0]               r_inc;
  logic [6:0]                r_count;
  logic [6:0]                r_h;
  logic [DIVISOR_BITS-1:0]   r_level;
  logic [DIVISOR_BITS-1:0]   r_decay;
  logic [SINE_ADDR_BITS-1:0] r_sine_addr;
  logic                      r_clear;
  logic                      r_start;
  logic [DIVISOR_BITS-1:0]   r_multiple;
  logic signed [15:0]        r_sample;
  logic signed [15:0]        r_output;
  logic                      r_valid;
  logic                      r_overrun;

  logic                      w_ready;
  logic                      w_accept;
  logic                      w_nyquist;
  logic [31:0]               w_phase;
  logic [31:0]               w_new_phase;
  logic [6:0]                w_h_next;
  logic [HAW-1:0]            w_ram_addr;
  logic                      w_ram_we;
  logic signed [31:0]        w_shifted;

  // A tick landing on the Valid cycle is refused so every result is observable.
  assign w_accept    = i_Sample_Tick && (r_state == ST_IDLE) && w_ready && !r_valid;
  assign w_nyquist   = r_inc[32] | r_inc[31];
  assign w_new_phase = w_phase + r_inc[31:0];
  assign w_h_next    = r_h + 7'd1;
  assign w_shifted   = i_Accumulator >>> OUTPUT_SHIFT;
  assign w_ram_we    = (r_state == ST_PHASE) && !w_nyquist;

  // Read h in CLEAR, read-ahead h+1 while waiting, write h in PHASE.
  always_comb begin
    w_ram_addr = r_h[HAW-1:0];
    if (r_state == ST_WAIT)
      w_ram_addr = w_h_next[HAW-1:0];
  end

  harmonic_phase_ram #(
    .DEPTH(MAX_HARMONICS)
  ) u_phase_ram (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Addr   (w_ram_addr),
    .i_Wr_En  (w_ram_we),
    .i_Wr_Data(w_new_phase),
    .o_Rd_Data(w_phase),
    .o_Ready  (w_ready)
  );

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state     <= ST_IDLE;
      r_freq      <= '0;
      r_inc       <= '0;
      r_count     <= '0;
      r_h         <= '0;
      r_level     <= '0;
      r_decay     <= '0;
      r_sine_addr <= '0;
      r_clear     <= 1'b0;
      r_start     <= 1'b0;
      r_multiple  <= '0;
      r_sample    <= '0;
      r_output    <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_clear   <= 1'b0;
      r_start   <= 1'b0;
      r_valid   <= 1'b0;
      r_overrun <= i_Sample_Tick && !w_accept;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_freq  <= i_Freq_Inc;
            r_inc   <= {1'b0, i_Freq_Inc};
            r_count <= (i_Harmonic_Count > MAX_COUNT) ? MAX_COUNT : i_Harmonic_Count;
            r_level <= i_Start_Level;
            r_decay <= i_Level_Decay;
            r_h     <= '0;
            r_clear <= 1'b1;
            r_state <= ST_CLEAR;
          end
        end
        ST_CLEAR: r_state <= (r_count == '0) ? ST_OUTPUT : ST_PHASE;
        ST_PHASE: begin
          if (w_nyquist) begin
            r_state <= ST_OUTPUT;
          end else begin
            r_sine_addr <= w_new_phase[31 -: SINE_ADDR_BITS];
            r_state     <= ST_SINE;
          end
        end
        ST_SINE: begin
          r_sample   <= i_Sine_Data;
          r_multiple <= r_level;
          r_start    <= 1'b1;
          r_state    <= ST_START;
        end
        ST_START: r_state <= ST_ACK;
        ST_ACK:   r_state <= ST_WAIT;
        ST_WAIT: begin
          if (i_Adder_Done) begin
            r_h     <= w_h_next;
            r_inc   <= r_inc + {1'b0, r_freq};
            r_level <= (r_level > r_decay) ? r_level - r_decay : '0;
            r_state <= (w_h_next == r_count) ? ST_OUTPUT : ST_PHASE;
          end
        end
        ST_OUTPUT: begin
          r_output <= sat16(w_shifted);
          r_valid  <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_Sine_Addr         = r_sine_addr;
  assign o_Clear_Accumulator = r_clear;
  assign o_Start             = r_start;
  assign o_Multiple          = r_multiple;
  assign o_Sample            = r_sample;
  assign o_Output            = r_output;
  assign o_Output_Valid      = r_valid;
  assign o_Overrun           = r_overrun;

endmodule
